// File: rtl/cv32e40x_irq_conditioner.sv
// rtl/cv32e40x_irq_conditioner.sv - synchronises external irq lines and turns edge lines into sticky pending bits
module cv32e40x_irq_conditioner #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [31:0] EDGE_MASK   = 32'h0000_0000,
   parameter logic [31:0] VALID_MASK  = 32'hFFFF_0888
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] irq_ext_i,
   input  logic        irq_ack_i,
   input  logic [4:0]  irq_ack_id_i,
   input  logic [31:0] pend_clr_i,
   output logic [31:0] irq_o,
   output logic [31:0] pend_o,
   output logic [31:0] irq_sync_o
);

   // Only implemented lines can ever hold pending state
   localparam logic [31:0] EDGE_BITS = EDGE_MASK & VALID_MASK;

   logic [31:0] s;
   logic [31:0] s_q;
   logic [31:0] pend_q;
   logic [31:0] pend_next;
   logic [31:0] rise;
   logic [31:0] ack_clr;
   logic [31:0] irq_q;

   generate
      if (SYNC_STAGES == 0) begin : g_bypass
         // Source is already in the clk domain, so pass it straight through
         assign s = irq_ext_i & VALID_MASK;
      end else begin : g_sync
         logic [31:0] sync_q [SYNC_STAGES];

         // Per-bit synchroniser chain; masking up front lets unused lines vanish
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int k = 0; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= '0;
               end
            end else begin
               sync_q[0] <= irq_ext_i & VALID_MASK;
               for (int k = 1; k < SYNC_STAGES; k++) begin
                  sync_q[k] <= sync_q[k-1];
               end
            end
         end

         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Decode the acknowledged id into a one-hot clear vector
   always_comb begin
      ack_clr = '0;
      if (irq_ack_i) begin
         ack_clr[irq_ack_id_i] = 1'b1;
      end
   end

   // A new edge wins over any clear in the same cycle so no edge is lost
   always_comb begin
      rise      = s & ~s_q & EDGE_BITS;
      pend_next = (rise | (pend_q & ~ack_clr & ~pend_clr_i)) & EDGE_BITS;
   end

   // Previous level, pending bits and the registered irq vector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= '0;
         pend_q <= '0;
         irq_q  <= '0;
      end else begin
         s_q    <= s;
         pend_q <= pend_next;
         irq_q  <= ((s & ~EDGE_MASK) | pend_next) & VALID_MASK;
      end
   end

   assign irq_o      = irq_q;
   assign pend_o     = pend_q;
   assign irq_sync_o = s;

endmodule

// File: tb/tb_cv32e40x_irq_conditioner.sv
// tb/tb_cv32e40x_irq_conditioner.sv - randomized and directed self-checking bench for cv32e40x_irq_conditioner
module tb_cv32e40x_irq_conditioner;

   localparam logic [31:0] VM   = 32'hFFFF_0888;
   localparam logic [31:0] EM_A = 32'h0001_0000;
   localparam logic [31:0] EM_B = 32'h0002_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] irq_ext = '0;
   logic        ack = 1'b0;
   logic [4:0]  ack_id = '0;
   logic [31:0] pend_clr = '0;

   logic [31:0] irq_a, pend_a, sync_a;
   logic [31:0] irq_b, pend_b, sync_b;

   int n_total = 0;
   int n_pass  = 0;

   // Model state: index 0 = dut_a (2-stage sync), index 1 = dut_b (bypass)
   logic [31:0] m_prev [2];
   logic [31:0] m_pend [2];
   logic [31:0] m_irq  [2];
   logic [31:0] hist_a [$];

   always #5 clk = ~clk;

   cv32e40x_irq_conditioner #(
      .SYNC_STAGES(2), .EDGE_MASK(EM_A), .VALID_MASK(VM)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .irq_ext_i(irq_ext), .irq_ack_i(ack),
      .irq_ack_id_i(ack_id), .pend_clr_i(pend_clr),
      .irq_o(irq_a), .pend_o(pend_a), .irq_sync_o(sync_a)
   );

   cv32e40x_irq_conditioner #(
      .SYNC_STAGES(0), .EDGE_MASK(EM_B), .VALID_MASK(VM)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .irq_ext_i(irq_ext), .irq_ack_i(ack),
      .irq_ack_id_i(ack_id), .pend_clr_i(pend_clr),
      .irq_o(irq_b), .pend_o(pend_b), .irq_sync_o(sync_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // One clock of the behavioural rules: edge seen on s sets, ack/clear drop, set wins
   task automatic model_edge(input int idx, input logic [31:0] s, input logic [31:0] em);
      logic [31:0] clr;
      logic [31:0] rose;
      clr  = pend_clr | (ack ? (32'd1 << ack_id) : 32'd0);
      rose = s & ~m_prev[idx] & em & VM;
      m_pend[idx] = ((m_pend[idx] & ~clr) | rose) & em & VM;
      m_irq[idx]  = ((s & ~em) | m_pend[idx]) & VM;
      m_prev[idx] = s;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 2; i++) begin
         m_prev[i] = '0;
         m_pend[i] = '0;
         m_irq[i]  = '0;
      end
      hist_a = {32'h0, 32'h0};
   endtask

   // Reference model: the 2-stage source sees the input sampled one edge earlier
   initial begin
      model_clear();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_clear();
         end else begin
            model_edge(0, hist_a[0] & VM, EM_A);
            model_edge(1, irq_ext & VM, EM_B);
            hist_a.push_back(irq_ext & VM);
            void'(hist_a.pop_front());
         end
      end
   end

   // Compare every output of both instances mid-cycle
   initial begin
      forever begin
         @(negedge clk);
         chk("irq_a",  irq_a,  m_irq[0]);
         chk("pend_a", pend_a, m_pend[0]);
         chk("sync_a", sync_a, hist_a[0] & VM);
         chk("irq_b",  irq_b,  m_irq[1]);
         chk("pend_b", pend_b, m_pend[1]);
         chk("sync_b", sync_b, irq_ext & VM);
      end
   end

   initial begin
      // Reset state
      step(3);
      chk("rst_irq_a", irq_a, 32'h0);
      chk("rst_pend_a", pend_a, 32'h0);
      rst_n = 1'b1;
      step(1);
      chk("post_rst_irq_a", irq_a, 32'h0);
      chk("post_rst_sync_a", sync_a, 32'h0);

      // Level propagation and bypass latency
      irq_ext = 32'h0000_0808;
      #1;
      chk("byp_sync_b", sync_b, 32'h0000_0808);
      step(1);
      chk("byp_irq_b", irq_b, 32'h0000_0808);
      chk("lvl_irq_a_e0", irq_a, 32'h0);
      step(1);
      chk("lvl_irq_a_e1", irq_a, 32'h0);
      step(1);
      chk("lvl_irq_a_e2", irq_a, 32'h0000_0808);
      chk("lvl_pend_a", pend_a, 32'h0);
      irq_ext = 32'h0;
      step(2);
      chk("lvl_hold_a", irq_a, 32'h0000_0808);
      step(1);
      chk("lvl_drop_a", irq_a, 32'h0);

      // Edge latch on line 16, persistence, acks
      irq_ext = 32'h0001_0000;
      step(1);
      irq_ext = 32'h0;
      step(2);
      chk("edge_pend_a", pend_a, 32'h0001_0000);
      chk("edge_irq_a", irq_a, 32'h0001_0000);
      step(10);
      chk("edge_persist_a", irq_a, 32'h0001_0000);
      ack = 1'b1; ack_id = 5'd17;
      step(1);
      ack = 1'b0;
      step(1);
      chk("ack17_ignored", pend_a, 32'h0001_0000);
      ack = 1'b1; ack_id = 5'd16;
      step(1);
      ack = 1'b0;
      chk("ack16_irq", irq_a, 32'h0);
      chk("ack16_pend", pend_a, 32'h0);

      // Set-over-clear: re-pend, then new edge reaches s while clear is asserted
      irq_ext = 32'h0001_0000;
      step(1);
      irq_ext = 32'h0;
      step(2);
      chk("repend", pend_a, 32'h0001_0000);
      step(2);
      irq_ext = 32'h0001_0000;
      step(1);
      irq_ext = 32'h0;
      step(1);
      pend_clr = 32'h0001_0000;
      step(1);
      pend_clr = 32'h0;
      chk("set_over_clr", pend_a, 32'h0001_0000);
      pend_clr = 32'h0001_0000;
      step(1);
      pend_clr = 32'h0;
      chk("clr_only", pend_a, 32'h0);

      // Masking
      irq_ext = 32'hFFFF_FFFF;
      step(3);
      chk("mask_irq_a", irq_a, 32'hFFFF_0888);
      chk("mask_irq_b", irq_b, 32'hFFFF_0888);
      chk("mask_pend_a", pend_a, 32'h0001_0000);

      // Asynchronous reset mid-operation, line 16 held through release
      #1;
      rst_n = 1'b0;
      irq_ext = 32'h0001_0000;
      #1;
      chk("arst_irq_a", irq_a, 32'h0);
      chk("arst_pend_a", pend_a, 32'h0);
      chk("arst_sync_a", sync_a, 32'h0);
      chk("arst_irq_b", irq_b, 32'h0);
      step(2);
      rst_n = 1'b1;
      step(2);
      chk("rel_pend_early", pend_a, 32'h0);
      step(1);
      chk("rel_pend_set", pend_a, 32'h0001_0000);

      // Randomized phase against the model
      for (int c = 0; c < 3000; c++) begin
         irq_ext  = irq_ext ^ ($urandom & $urandom & $urandom);
         ack      = ($urandom_range(0, 3) == 0);
         ack_id   = 5'($urandom_range(0, 31));
         pend_clr = ($urandom_range(0, 3) == 0) ? ($urandom & 32'h0003_0000) : 32'h0;
         if ($urandom_range(0, 299) == 0) begin
            rst_n = 1'b0;
            step(2);
            rst_n = 1'b1;
         end
         step(1);
      end
      ack = 1'b0;
      pend_clr = '0;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/cv32e40x_irq_conditioner.md
Name: cv32e40x_irq_conditioner

Overview:
- Sits directly upstream of the interrupt controller.
- Takes raw, asynchronous external interrupt lines and synchronises them into the core clock domain.
- Each line is configured as level- or rising-edge-sensitive. Edge lines are converted into sticky pending bits, so the interrupt controller always sees a clean, registered, level-style 32-bit irq vector.
- Edge-pending bits are cleared by the controller's interrupt acknowledge or by an explicit clear vector from the CSR side.

Parameters:
- SYNC_STAGES, 2: flops in each per-bit synchroniser chain. Legal values are 0 or 2..4. 0 bypasses synchronisation for already-synchronous sources.
- EDGE_MASK, 32'h0000_0000: bit i = 1 makes line i rising-edge-sensitive; bit i = 0 makes it level-sensitive.
- VALID_MASK, 32'hFFFF_0888: lines implemented (custom 31:16, MEI 11, MTI 7, MSI 3). Bits outside the mask are constant 0 everywhere.

Ports:
- clk, input, 1: core clock.
- rst_n, input, 1: asynchronous active-low reset.
- irq_ext_i, input, 32: raw external interrupt lines, asynchronous to clk.
- irq_ack_i, input, 1: single-cycle pulse from the controller when an interrupt is taken.
- irq_ack_id_i, input, 5: id of the taken interrupt; qualified by irq_ack_i.
- pend_clr_i, input, 32: single-cycle per-bit clear of edge-pending bits, from the CSR write path.
- irq_o, output, 32: conditioned irq vector to the interrupt controller's irq_i.
- pend_o, output, 32: edge-pending register, for CSR readback and debug.
- irq_sync_o, output, 32: synchronised raw level, for the wake-up path.

Behaviour:
- **Reset:** rst_n low asynchronously clears all synchroniser flops, the previous-level register and the pending register. irq_o, pend_o and irq_sync_o are 0 during reset and in the first cycle after it. Reset asserted mid-operation discards any pending edges.
- **Synchroniser:** s = last stage of a SYNC_STAGES-deep chain, per bit, masked by VALID_MASK.
  - A level change on irq_ext_i that is stable before rising edge k appears on s after edge k+SYNC_STAGES-1.
  - With the default of 2, that is 2 clocks of latency.
  - With SYNC_STAGES = 0, s = irq_ext_i & VALID_MASK combinationally.
  - irq_sync_o = s.
- **Previous-level register:** s_q <= s every cycle; resets to 0.
- **Rising-edge detect (edge bits only):** rise[i] = s[i] & ~s_q[i] & EDGE_MASK[i].
  - A line held high through reset release counts as a rising edge once it reaches s.
- **Acknowledge clear:** ack_clr[i] = irq_ack_i & (irq_ack_id_i == i).
- **Pending update, per edge bit:** pend_next = rise | (pend & ~ack_clr & ~pend_clr_i).
  - Set has priority over clear: a new edge in the same cycle as an ack or pend_clr leaves the bit set, so no edge is lost.
- **Level bits:** pend[i] is constant 0, and ack/clear have no effect.
- **Output register:** irq_o is registered: irq_o <= ((s & ~EDGE_MASK) | pend_next) & VALID_MASK. This gives no combinational path from any input to irq_o.
  - Level latency is SYNC_STAGES+1 cycles.
  - Edge latency is SYNC_STAGES+1 cycles from the stable edge to irq_o high.
  - An edge bit stays high on irq_o until cleared, regardless of the input.
- **pend_o:** equals the pending register (the registered value).
- **Repeated edges:** multiple edges while a bit is pending collapse to one pending bit; there is no counting.
- **Ack for an invalid or level id:** ignored.
- **Input glitches:** a pulse shorter than one clock may be missed. This is legal for level lines; edge sources must hold high for at least 1 clock.

Test Plan:
1. **Level propagation:** SYNC_STAGES=2, EDGE_MASK=0. irq_ext_i[11] rises just before edge 0 → irq_o[11]=1 after edge 2 (3 cycles with output reg). Deassert → irq_o[11]=0 three cycles later. pend_o stays 0.
2. **Edge latch and ack:** EDGE_MASK bit 16 = 1. Pulse irq_ext_i[16] high for 1 clock → irq_o[16]=1 and pend_o[16]=1 persist indefinitely. irq_ack_i=1 with irq_ack_id_i=16 → irq_o[16]=0 the next cycle. Ack with id 17 instead → no change.
3. **Set-over-clear:** a new rising edge on line 16 reaches s in the same cycle as pend_clr_i[16]=1 while pend_o[16]=1 → pend_o[16] remains 1.
4. **Masking:** drive irq_ext_i=32'hFFFF_FFFF with default VALID_MASK → irq_o=32'hFFFF_0888 (level mode). Bits 15:12, 10:8, 6:4 and 2:0 stay 0.
5. **Reset mid-operation:** pend_o=32'h0001_0000 and a level irq is active; assert rst_n=0 asynchronously → all outputs 0 immediately. Release with line 16 held high → pending bit re-set SYNC_STAGES+1 cycles after release.
6. **Bypass:** SYNC_STAGES=0. irq_ext_i[3] high before edge 0 → irq_o[3]=1 after edge 0 (1-cycle latency) and irq_sync_o[3]=1 combinationally.
